// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - in-order write-through store buffer between the data cache and data memory
// Optional macro WB_FORWARD_EN: forward the youngest full-word match to loads instead of stalling.
module store_write_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [ADDR_WIDTH-1:0]    push_addr,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic [2:0]               push_mode,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic [2:0]               mem_mode,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic                     rd_conflict,
  output logic                     fwd_hit,
  output logic [DATA_WIDTH-1:0]    fwd_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] DATA_ADDR_MODE_WORD = 3'b010;

  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [2:0]            mode_q [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;
  logic [DEPTH-1:0]      match;
  logic                  rd_addr_unused;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign mem_we   = !empty;
  assign mem_addr = empty ? '0 : addr_q[head_q];
  assign mem_wd   = empty ? '0 : data_q[head_q];
  assign mem_mode = empty ? '0 : mode_q[head_q];
  assign push_ok  = push_valid && !full;
  assign pop_ok   = mem_we && mem_ready;
  assign rd_addr_unused = ^rd_addr[1:0];

  always_comb begin
    head_d  = pop_ok  ? head_q + PW'(1) : head_q;
    tail_d  = push_ok ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Push and pop can never hit the same slot: that needs count 0 (no pop) or DEPTH (no push).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_ok) valid_q[tail_q] <= 1'b1;
      if (pop_ok)  valid_q[head_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
      mode_q[tail_q] <= push_mode;
    end
  end

  always_ff @(posedge clk) begin
    WB_OVERFLOW: assert (rst || !(push_valid && full))
      else $warning("WB_OVERFLOW: store pushed while buffer full was dropped");
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (addr_q[i][ADDR_WIDTH-1:2] == rd_addr[ADDR_WIDTH-1:2]);
    end
  end

`ifdef WB_FORWARD_EN
  logic          found;
  logic [PW-1:0] sel, idx;
  logic          sel_word;

  // Youngest first: tail-1 back toward head; the oldest slot wraps to tail when full.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail_q - PW'(k + 1);
      if (!found && match[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_word    = (mode_q[sel] == DATA_ADDR_MODE_WORD);
  assign fwd_hit     = rd_en && found && sel_word;
  assign fwd_data    = fwd_hit ? data_q[sel] : '0;
  assign rd_conflict = rd_en && found && !sel_word;
`else
  assign fwd_hit     = 1'b0;
  assign fwd_data    = '0;
  assign rd_conflict = rd_en && (|match);
`endif

endmodule
